// File: rtl/text_console_if.sv
// UART receive-FIFO pop handshake and font ROM lookup bus of the text console.
interface text_console_if;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rd_uart;
    logic [10:0] font_addr;
    logic [7:0]  font_data;

    modport master (output rx_data, output rx_empty, input rd_uart,
                    input font_addr, output font_data);
    modport slave  (input rx_data, input rx_empty, output rd_uart,
                    output font_addr, input font_data);
endinterface

// File: rtl/text_console_ctrl.sv
// Character-cell text console: UART byte decoder with cursor, character RAM,
// screen clear, and a three-stage glyph render pipeline with blinking cursor.
module text_console_ctrl #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter int         BLINK_CYCLES = 12500000,
    parameter logic [2:0] FG_RGB       = 3'b010,
    parameter logic [2:0] CUR_RGB      = 3'b011
) (
    input  logic          clk,
    input  logic          rst_n,
    text_console_if.slave bus,
    input  logic          key_right_tick,
    input  logic          key_down_tick,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          video_on,
    output logic [2:0]    rgb,
    output logic          busy,
    output logic [6:0]    cursor_x,
    output logic [4:0]    cursor_y
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [6:0]    X_LAST   = 7'(COLS - 1);
    localparam logic [4:0]    Y_LAST   = 5'(ROWS - 1);
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, DECODE, CLEAR} state_t;
    state_t state, state_nxt;

    logic [6:0]    cur_x, cur_y_pad, x_nxt;
    logic [4:0]    cur_y, y_nxt;
    logic [7:0]    rx_byte;
    logic [AW-1:0] clr_addr;
    logic          rst_done, rd_pop, cur_upd;
    logic          ram_we;
    logic [AW-1:0] ram_waddr, rd_addr;
    logic [6:0]    ram_wdata;
    logic [6:0]    char_ram [DEPTH];

    function automatic logic [4:0] next_row(input logic [4:0] y);
        return (y == Y_LAST) ? 5'd0 : y + 5'd1;
    endfunction

    // Returns {y, x} after one step right with line and screen wrap.
    function automatic logic [11:0] advance(input logic [6:0] x, input logic [4:0] y);
        if (x == X_LAST) return {next_row(y), 7'd0};
        return {y, x + 7'd1};
    endfunction

    function automatic logic [11:0] lin_addr(input logic [6:0] x, input logic [4:0] y);
        return 12'(y) * 12'(COLS) + 12'(x);
    endfunction

    assign cur_y_pad = {2'b00, cur_y};

    always_comb begin
        state_nxt = state;
        x_nxt     = cur_x;
        y_nxt     = cur_y;
        rd_pop    = 1'b0;
        cur_upd   = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = AW'(lin_addr(cur_x, cur_y));
        ram_wdata = 7'h20;
        case (state)
            IDLE: begin
                if (rst_done && !bus.rx_empty) begin
                    rd_pop    = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = IDLE;
                if (rx_byte >= 8'h20 && rx_byte <= 8'h7E) begin
                    ram_we         = 1'b1;
                    ram_wdata      = rx_byte[6:0];
                    cur_upd        = 1'b1;
                    {y_nxt, x_nxt} = advance(cur_x, cur_y);
                end else begin
                    case (rx_byte)
                        8'h0D: begin x_nxt = 7'd0; cur_upd = 1'b1; end
                        8'h0A: begin y_nxt = next_row(cur_y); cur_upd = 1'b1; end
                        8'h08: begin
                            if (cur_x != 7'd0) begin
                                x_nxt     = cur_x - 7'd1;
                                ram_we    = 1'b1;
                                ram_waddr = AW'(lin_addr(cur_x - 7'd1, cur_y));
                                cur_upd   = 1'b1;
                            end
                        end
                        8'h0C:   state_nxt = CLEAR;
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                if (clr_addr == CLR_LAST) begin
                    state_nxt = IDLE;
                    x_nxt     = 7'd0;
                    y_nxt     = 5'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Manual moves only land when the decoder leaves the cursor alone.
        if (state != CLEAR && !cur_upd) begin
            if (key_right_tick) {y_nxt, x_nxt} = advance(x_nxt, y_nxt);
            if (key_down_tick)  y_nxt = next_row(y_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_x    <= 7'd0;
            cur_y    <= 5'd0;
            clr_addr <= '0;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_x    <= x_nxt;
            cur_y    <= y_nxt;
            clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pop) rx_byte <= bus.rx_data;
        if (ram_we) char_ram[ram_waddr] <= ram_wdata;
    end

    assign bus.rd_uart = rd_pop;
    assign busy        = (state == CLEAR);
    assign cursor_x    = cur_x;
    assign cursor_y    = cur_y;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Stage 0: character RAM lookup for the incoming pixel's cell.
    logic       in_range_p0;
    logic [6:0] char_p1;
    assign in_range_p0 = int'(pixel_x[9:3]) < COLS && int'(pixel_y[8:4]) < ROWS;
    assign rd_addr     = in_range_p0 ? AW'(lin_addr(pixel_x[9:3], pixel_y[8:4])) : '0;

    always_ff @(posedge clk) char_p1 <= char_ram[rd_addr];

    logic [9:0] pixel_x_p1, pixel_y_p1, pixel_x_p2, pixel_y_p2;
    logic       vld_p1, vld_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x_p1 <= '0;
            pixel_y_p1 <= '0;
            vld_p1     <= 1'b0;
            pixel_x_p2 <= '0;
            pixel_y_p2 <= '0;
            vld_p2     <= 1'b0;
        end else begin
            pixel_x_p1 <= pixel_x;
            pixel_y_p1 <= pixel_y;
            vld_p1     <= video_on;
            pixel_x_p2 <= pixel_x_p1;
            pixel_y_p2 <= pixel_y_p1;
            vld_p2     <= vld_p1;
        end
    end

    // Stage 1: font ROM row address; ROM answers one cycle later.
    assign bus.font_addr = {char_p1, pixel_y_p1[3:0]};

    // Stage 2: pick the glyph bit and overlay the cursor underline.
    logic [6:0] col_p2;
    logic [4:0] row_p2;
    logic       glyph_bit;
    assign col_p2    = pixel_x_p2[9:3];
    assign row_p2    = pixel_y_p2[8:4];
    assign glyph_bit = bus.font_data[~pixel_x_p2[2:0]];

    always_comb begin
        rgb = 3'b000;
        if (vld_p2 && int'(col_p2) < COLS && int'(row_p2) < ROWS) begin
            if ({2'b00, row_p2} == cur_y_pad && col_p2 == cur_x &&
                pixel_y_p2[3:1] == 3'b111 && blink_phase)
                rgb = CUR_RGB;
            else if (glyph_bit)
                rgb = FG_RGB;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pixel_y[9], pixel_y_p2[9], pixel_y_p2[0]};
endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomized and directed bench for text_console_ctrl against a cell-level
// console model, a queue-based UART FIFO and a hashed font ROM.
`timescale 1ns/1ps
module tb_text_console_ctrl;
    localparam int COLS   = 10;
    localparam int ROWS   = 6;
    localparam int DEPTH  = COLS * ROWS;
    localparam int BLINK  = 37;
    localparam logic [2:0] FG  = 3'b010;
    localparam logic [2:0] CUR = 3'b011;
    localparam int SCAN_W = 8 * COLS + 8;
    localparam int SCAN_H = 16 * ROWS + 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_right_tick = 1'b0, key_down_tick = 1'b0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic       video_on = 1'b0;
    logic [2:0] rgb;
    logic       busy;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;

    text_console_if tif();

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(BLINK),
                        .FG_RGB(FG), .CUR_RGB(CUR)) dut (
        .clk(clk), .rst_n(rst_n), .bus(tif),
        .key_right_tick(key_right_tick), .key_down_tick(key_down_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .rgb(rgb), .busy(busy), .cursor_x(cursor_x), .cursor_y(cursor_y));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int cyc;
    int mx = 0, my = 0;
    int mram [DEPTH];
    logic [7:0] fifo [$];

    function automatic logic [7:0] font_fn(input int a);
        return 8'(((a * 151) ^ (a >> 4)) & 255);
    endfunction

    always @(posedge clk) tif.font_data <= font_fn(int'(tif.font_addr));

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    // UART FIFO: pops on rd_uart, presents head a moment after the edge.
    initial begin
        tif.rx_empty = 1'b1;
        tif.rx_data  = 8'h00;
        forever begin
            @(posedge clk);
            if (tif.rd_uart) begin
                vectors++;
                assert (fifo.size() != 0) else begin
                    miscompares++;
                    $error("FAIL rd_uart_pop obs=pop_while_empty exp=no_pop");
                end
                if (fifo.size() != 0) void'(fifo.pop_front());
                pop_cnt++;
            end
            #1;
            tif.rx_empty = (fifo.size() == 0);
            tif.rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_x"}, 32'(cursor_x), 32'(mx));
        check({tag, "_y"}, 32'(cursor_y), 32'(my));
    endtask

    function automatic void model_adv();
        int lin = (my * COLS + mx + 1) % DEPTH;
        mx = lin % COLS;
        my = lin / COLS;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            mram[my * COLS + mx] = int'(b);
            model_adv();
        end else if (b == 8'h0D) mx = 0;
        else if (b == 8'h0A) my = (my + 1) % ROWS;
        else if (b == 8'h08) begin
            if (mx > 0) begin
                mx = mx - 1;
                mram[my * COLS + mx] = 32'h20;
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < DEPTH; i++) mram[i] = 32'h20;
            mx = 0;
            my = 0;
        end
    endfunction

    function automatic bit phase_now();
        return ((cyc / BLINK) % 2) == 0;
    endfunction

    function automatic logic [2:0] exp_rgb(input int x, input int y, input bit v);
        int col = x / 8;
        int row = y / 16;
        logic [7:0] bits;
        if (!v || col >= COLS || row >= ROWS) return 3'b000;
        if (col == mx && row == my && (y % 16) >= 14 && phase_now()) return CUR;
        bits = font_fn(mram[row * COLS + col] * 16 + (y % 16));
        return bits[7 - (x % 8)] ? FG : 3'b000;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        push_cnt++;
        model_byte(b);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 4 * DEPTH + 100) begin
            @(negedge clk);
            n++;
            if (fifo.size() == 0 && busy === 1'b0) quiet++;
            else quiet = 0;
        end
        check("idle_wait", 32'(quiet >= 3), 32'd1);
    endtask

    task automatic feed(input logic [7:0] b, input string tag);
        @(negedge clk);
        push(b);
        wait_idle();
        check_cursor(tag);
    endtask

    task automatic key(input bit r, input bit d);
        @(negedge clk);
        key_right_tick = r;
        key_down_tick  = d;
        if (r) model_adv();
        if (d) my = (my + 1) % ROWS;
        @(negedge clk);
        key_right_tick = 1'b0;
        key_down_tick  = 1'b0;
        check_cursor("key");
    endtask

    task automatic scan_screen(input string tag);
        int n = SCAN_W * SCAN_H;
        int hx [3];
        int hy [3];
        bit hv [3];
        logic [2:0] e;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = exp_rgb(hx[(i - 2) % 3], hy[(i - 2) % 3], hv[(i - 2) % 3]);
                vectors++;
                assert (rgb === e) else begin
                    miscompares++;
                    $error("FAIL rgb_%s x=%0d y=%0d obs=%0d exp=%0d", tag,
                           hx[(i - 2) % 3], hy[(i - 2) % 3], rgb, e);
                end
            end
            if (i < n) begin
                hx[i % 3] = i % SCAN_W;
                hy[i % 3] = i / SCAN_W;
                hv[i % 3] = ($urandom_range(0, 15) != 0);
                pixel_x   = 10'(hx[i % 3]);
                pixel_y   = 10'(hy[i % 3]);
                video_on  = hv[i % 3];
            end else begin
                video_on = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 19);
        if (r < 11)  return 8'($urandom_range(32, 126));
        if (r < 13)  return 8'h0D;
        if (r < 15)  return 8'h0A;
        if (r < 17)  return 8'h08;
        if (r == 17) return 8'h0C;
        if (r == 18) return 8'($urandom_range(127, 255));
        return 8'($urandom_range(0, 7));
    endfunction

    initial begin
        int w;
        int cnt;
        int nb;
        for (int i = 0; i < DEPTH; i++) mram[i] = -1;

        // Reset state with a visible pixel request.
        rst_n = 1'b0;
        video_on = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cursor_x", 32'(cursor_x), 32'd0);
        check("rst_cursor_y", 32'(cursor_y), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_uart", 32'(tif.rd_uart), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        video_on = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rd_uart", 32'(tif.rd_uart), 32'd0);

        // Full clear with key ticks hammering throughout.
        key(1'b1, 1'b1);
        key(1'b1, 1'b1);
        @(negedge clk);
        push(8'h0C);
        w = 0;
        while (busy !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("clear_busy_rise", 32'(busy), 32'd1);
        cnt = 0;
        while (busy === 1'b1 && cnt < DEPTH + 20) begin
            key_right_tick = 1'($urandom_range(0, 1));
            key_down_tick  = 1'($urandom_range(0, 1));
            @(negedge clk);
            cnt++;
        end
        key_right_tick = 1'b0;
        key_down_tick  = 1'b0;
        check("clear_busy_cycles", 32'(cnt), 32'(DEPTH));
        wait_idle();
        check_cursor("clear_cursor");

        // Byte queued while in reset must wait for reset release.
        @(negedge clk);
        rst_n = 1'b0;
        mx = 0;
        my = 0;
        push(8'h41);
        repeat (4) begin
            @(negedge clk);
            check("rst_hold_rd_uart", 32'(tif.rd_uart), 32'd0);
        end
        rst_n = 1'b1;
        wait_idle();
        check_cursor("char_A");
        check("char_A_pops", 32'(pop_cnt), 32'(push_cnt));
        scan_screen("after_A");

        // Last cell wraps the cursor to the origin.
        repeat (COLS - 2) key(1'b1, 1'b0);
        repeat (ROWS - 1) key(1'b0, 1'b1);
        check("corner_x", 32'(cursor_x), 32'(COLS - 1));
        check("corner_y", 32'(cursor_y), 32'(ROWS - 1));
        feed(8'h42, "corner_wrap");
        scan_screen("corner");

        // Backspace, carriage return and line feed.
        repeat (4) key(1'b1, 1'b0);
        repeat (3) key(1'b0, 1'b1);
        feed(8'h5A, "put_Z");
        feed(8'h08, "bs_5_3");
        feed(8'h0D, "cr_to_0_3");
        feed(8'h08, "bs_at_col0");
        feed(8'h0D, "cr_again");
        feed(8'h0A, "lf_to_0_4");
        scan_screen("bs_cr_lf");

        // Random bursts of bytes and key ticks.
        for (int op = 0; op < 150; op++) begin
            if ($urandom_range(0, 9) < 6) begin
                nb = $urandom_range(1, 4);
                @(negedge clk);
                for (int b = 0; b < nb; b++) push(rand_byte());
                wait_idle();
                check_cursor("rand_bytes");
            end else begin
                case ($urandom_range(0, 2))
                    0:       key(1'b1, 1'b0);
                    1:       key(1'b0, 1'b1);
                    default: key(1'b1, 1'b1);
                endcase
            end
        end
        scan_screen("random");
        check("total_pops", 32'(pop_cnt), 32'(push_cnt));

        // Asynchronous reset aborts a clear in progress.
        while (mx == 0 && my == 0) key(1'b1, 1'b1);
        @(negedge clk);
        fifo.push_back(8'h0C);
        push_cnt++;
        w = 0;
        while (busy !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("abort_busy_rise", 32'(busy), 32'd1);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cursor_x", 32'(cursor_x), 32'd0);
        check("abort_cursor_y", 32'(cursor_y), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("abort_stays_idle", 32'(busy), 32'd0);
        end
        check("abort_pops", 32'(pop_cnt), 32'(push_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns (1..128).
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows (1..32).
REQ-003 SHALL have parameter BLINK_CYCLES, default 12500000, meaning clk cycles per cursor-blink half-period.
REQ-004 SHALL have parameter FG_RGB, default 3'b010, meaning glyph foreground colour.
REQ-005 SHALL have parameter CUR_RGB, default 3'b011, meaning cursor underline colour.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  system clock (pixel clock); rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: rx_data  in  8  UART FIFO head byte, valid whenever rx_empty=0; rx_empty  in  1  UART FIFO empty; rd_uart  out  1  one-cycle pop strobe.
REQ-008 SHALL have ports: key_right_tick  in  1  debounced move-right pulse; key_down_tick  in  1  debounced move-down pulse.
REQ-009 SHALL have ports: pixel_x  in  10; pixel_y  in  10; video_on  in  1 (from VGA sync).
REQ-010 SHALL have ports: font_addr  out  11  {ascii[6:0], glyph row[3:0]}; font_data  in  8  font ROM row, valid one cycle after font_addr.
REQ-011 SHALL have ports: rgb  out  3; busy  out  1  high during screen clear; cursor_x  out  7; cursor_y  out  5.

Function
REQ-012 SHALL contain a COLS*ROWS x 7-bit character RAM, one write port, one synchronous read port, linear address y*COLS+x.
REQ-013 SHALL implement FSM states IDLE, DECODE, CLEAR.
REQ-014 IDLE: if rx_empty=0, SHALL latch rx_data, assert rd_uart for exactly one cycle, enter DECODE; otherwise stay.
REQ-015 DECODE (one cycle, then IDLE): byte 0x20-0x7E SHALL be written at cursor, then cursor advances.
REQ-016 Advance: x+1; at x=COLS-1, x->0 and y->y+1; at y=ROWS-1, y->0.
REQ-017 0x0D SHALL set x=0; 0x0A SHALL set y=y+1 wrapping ROWS-1->0; x unchanged.
REQ-018 0x08 with x>0 SHALL set x=x-1 and write 0x20 there; with x=0, no effect.
REQ-019 0x0C SHALL enter CLEAR: write 0x20 to addresses 0..COLS*ROWS-1, one per cycle, busy=1, then cursor=(0,0), busy=0, IDLE.
REQ-020 All other byte values SHALL be consumed and ignored.
REQ-021 key_right_tick SHALL advance cursor per REQ-016; key_down_tick SHALL apply REQ-017 LF rule; both ticks same cycle: right applied, then down.
REQ-022 Key ticks coinciding with a DECODE cursor update, or during CLEAR, SHALL be dropped.
REQ-023 rd_uart SHALL not assert during DECODE or CLEAR.
REQ-024 Render stage 0: RAM read at col=pixel_x[9:3], row=pixel_y[8:4].
REQ-025 Stage 1: font_addr={char, pixel_y_d1[3:0]}.
REQ-026 Stage 2: pixel_x, pixel_y, video_on SHALL be delayed 2 cycles; bit=font_data[~pixel_x_d2[2:0]].
REQ-027 rgb (combinational from stage 2): 0 if video_on_d2=0 or col>=COLS or row>=ROWS; else CUR_RGB if cell=cursor, pixel_y_d2[3:1]=3'b111 and blink phase=1; else FG_RGB if bit=1; else 0.
REQ-028 Blink counter SHALL count 0..BLINK_CYCLES-1, toggling blink phase at wrap; phase reset value 1.
REQ-029 RAM write during render SHALL not stall or corrupt the read pipeline; a write at the displayed cell may show old or new char that frame.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, cursor (0,0), rd_uart=0, busy=0, blink counter 0, phase 1, delay registers 0, rgb 0.
REQ-031 Reset mid-CLEAR SHALL abort it; RAM contents are not reset (undefined until written or cleared).

Verification
REQ-032 Reset, feed 'A'(0x41) -> rd_uart one pulse, RAM[0]=0x41, cursor (1,0).
REQ-033 Cursor (COLS-1, ROWS-1), feed 0x42 -> RAM[COLS*ROWS-1]=0x42, cursor (0,0).
REQ-034 Feed 0x0C -> busy high exactly COLS*ROWS cycles, all RAM=0x20, cursor (0,0); key ticks during clear ignored.
REQ-035 Cursor (5,3), feed 0x08 -> cursor (4,3), RAM[3*COLS+4]=0x20; at (0,3) -> no change; feed 0x0D,0x0A -> (0,4).
REQ-036 RAM[0]=0x41, scan pixel (0..7,0..15) -> rgb matches font bits for 'A' with 2-cycle latency; cursor underline CUR_RGB on rows 14-15 only in blink phase 1; pixel_x>=8*COLS -> rgb 0.
